aiv_pixel_packer: RTL

Parametrised capture-side packer for the AIV video path. Takes the frame-tracked AIV pixel stream with its display enable and start-of-frame flag, applies a per-frame source mode, and packs pixels of BPC bits per channel into SRAM-width words. Each packed word carries a frame-start marker and a linear word address. Words are queued in a small FIFO and handed to the SRAM arbiter over a req/ack handshake. It generalises the fixed RGB111 capture into the framebuffer to wider colour depths, with solid-colour, blank and freeze modes and overflow accounting.

---
 rtl/aiv_pixel_packer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aiv_pixel_packer.sv
// Capture-side pixel packer: packs 3*BPC-bit pixels into SRAM-width words tagged
// with a frame marker and linear address, then queues them for the SRAM arbiter.
module aiv_pixel_packer #(
    parameter int BPC        = 1,
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 18,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        sysClk,
    input  logic                        reset,
    input  logic [3*BPC-1:0]            pix_in,
    input  logic                        de_in,
    input  logic                        sof_in,
    input  logic [1:0]                  mode_in,
    input  logic [3*BPC-1:0]            colour_in,
    output logic                        wr_req,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [WORD_W-1:0]           wr_data,
    input  logic                        wr_ack,
    output logic [1:0]                  active_mode,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [7:0]                  ovf_count,
    output logic                        ovf_sticky
);

    localparam int PIX_W   = 3 * BPC;
    localparam int PPW     = (WORD_W - 1) / PIX_W;
    localparam int FIELD_W = PPW * PIX_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int PC_W    = (PPW > 1) ? $clog2(PPW) : 1;

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_SOLID  = 2'd1,
        MODE_FREEZE = 2'd2,
        MODE_BLANK  = 2'd3
    } mode_e;

    mode_e               activeMode_q, activeMode_d, effMode;
    logic                enabled_q, enabled_d;
    logic                deDly_q;
    logic                marker_q, marker_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [FIELD_W-1:0]  hold_q, hold_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          ovfCount_q, ovfCount_d;
    logic                ovfSticky_q, ovfSticky_d;

    logic [WORD_W-1:0]   dataMem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   addrMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    rdPtr_q, wrPtr_q;
    logic [LVL_W-1:0]    level_q, level_d;

    logic                sofQual;
    logic                takePix;
    logic                flush;
    logic                pushReq;
    logic                pushOk;
    logic                drop;
    logic                pop;
    logic                full;
    logic                markerBase;
    logic [PIX_W-1:0]    srcPix;
    logic [PC_W-1:0]     pcBase;
    logic [FIELD_W-1:0]  holdBase;
    logic [FIELD_W-1:0]  filled;
    logic [ADDR_W-1:0]   addrBase;
    logic [7:0]          ovfBase;
    logic [WORD_W-1:0]   pushWord;

    // A qualified sof restarts the frame state before its own pixel is packed,
    // so every "base" value below is the post-sof view of the packer state.
    always_comb begin
        sofQual      = sof_in & de_in;
        effMode      = sofQual ? mode_e'(mode_in) : activeMode_q;
        activeMode_d = effMode;
        enabled_d    = enabled_q | sofQual;

        case (effMode)
            MODE_LIVE:  srcPix = pix_in;
            MODE_SOLID: srcPix = colour_in;
            default:    srcPix = '0;
        endcase

        holdBase   = sofQual ? '0 : hold_q;
        pcBase     = sofQual ? '0 : pc_q;
        markerBase = sofQual | marker_q;
        addrBase   = sofQual ? '0 : addr_q;
        ovfBase    = sofQual ? 8'd0 : ovfCount_q;

        takePix = enabled_d & de_in & (effMode != MODE_FREEZE);
        flush   = enabled_q & deDly_q & ~de_in & (pc_q != '0);

        filled = holdBase;
        if (takePix) begin
            for (int s = 0; s < PPW; s++) begin
                if (pcBase == PC_W'(s)) begin
                    filled[(PPW - s) * PIX_W - 1 -: PIX_W] = srcPix;
                end
            end
        end

        pushReq = flush | (takePix & (pcBase == PC_W'(PPW - 1)));

        pushWord                = '0;
        pushWord[WORD_W-1]      = markerBase;
        pushWord[FIELD_W-1:0]   = filled;

        hold_d   = pushReq ? '0 : filled;
        pc_d     = pushReq ? '0 : (takePix ? pcBase + 1'b1 : pcBase);
        marker_d = pushReq ? 1'b0 : markerBase;
        addr_d   = pushReq ? addrBase + 1'b1 : addrBase;

        pop    = (level_q != '0) & wr_ack;
        full   = (level_q == LVL_W'(FIFO_DEPTH));
        pushOk = pushReq & (~full | pop);
        drop   = pushReq & ~pushOk;

        ovfCount_d  = (drop && ovfBase != 8'hFF) ? ovfBase + 8'd1 : ovfBase;
        ovfSticky_d = ovfSticky_q | drop;

        case ({pushOk, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            activeMode_q <= MODE_LIVE;
            enabled_q    <= 1'b0;
            deDly_q      <= 1'b0;
            marker_q     <= 1'b0;
            pc_q         <= '0;
            hold_q       <= '0;
            addr_q       <= '0;
            ovfCount_q   <= 8'd0;
            ovfSticky_q  <= 1'b0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            level_q      <= '0;
        end else begin
            activeMode_q <= activeMode_d;
            enabled_q    <= enabled_d;
            deDly_q      <= de_in;
            marker_q     <= marker_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            ovfCount_q   <= ovfCount_d;
            ovfSticky_q  <= ovfSticky_d;
            level_q      <= level_d;
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is only exposed while level is non-zero.
    always_ff @(posedge sysClk) begin
        if (!reset && pushOk) begin
            dataMem_q[wrPtr_q] <= pushWord;
            addrMem_q[wrPtr_q] <= addrBase;
        end
    end

    assign wr_req      = (level_q != '0);
    assign wr_addr     = wr_req ? addrMem_q[rdPtr_q] : '0;
    assign wr_data     = wr_req ? dataMem_q[rdPtr_q] : '0;
    assign active_mode = activeMode_q;
    assign fifo_level  = level_q;
    assign ovf_count   = ovfCount_q;
    assign ovf_sticky  = ovfSticky_q;

endmodule
